sub_32bit_seq: RTL
==================

Name: sub_32bit_seq

Overview:
- Multi-cycle 32-bit subtractor for the ArithmeticUnit; the inverse operation of the combinational 32-bit adder.
- Computes diff = a - b as a + ~b + 1, one CHUNK-bit slice per clock, with the carry held between slices.
- Uses a start/busy/done handshake so the ALU sequencer can trade latency for area.
- Produces borrow, signed-overflow and zero flags alongside the result.

Parameters:
- WIDTH, 32: operand and result width.
- CHUNK, 8: bits processed per RUN cycle. Must divide WIDTH exactly. N = WIDTH/CHUNK (default 4).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request pulse; sampled only when busy=0.
- a, input, WIDTH: minuend; latched on an accepted start.
- b, input, WIDTH: subtrahend; latched on an accepted start.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse; result and flags are valid in this cycle.
- diff, output, WIDTH: a - b modulo 2^WIDTH, registered.
- borrow, output, 1: 1 when a < b as unsigned values.
- overflow, output, 1: signed overflow, (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- zero, output, 1: 1 when diff == 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, borrow=0, overflow=0, zero=0.
  - Operand registers, slice index and carry are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E: latch a and b, slice index=0, carry=1, move to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge computes slice i: {c, s} = a[i] + ~b[i] + carry, writes s into diff_work[i], sets carry=c, increments i.
  - On the edge that processes slice N-1, load the outputs and move to DONE:
    - diff from diff_work.
    - borrow = ~c.
    - overflow per the formula above.
    - zero = (final diff == 0).
  - start is ignored in RUN, and a/b input changes have no effect.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back; the new operands are latched).
- Latency:
  - start sampled at edge E; done high in the cycle following edge E+N.
  - Back-to-back throughput: one result per N+1 cycles.
- Holding outputs:
  - diff and the flags hold their values until the next completion or reset.
  - They never change during RUN; only the internal diff_work changes.
- Wrap-around: results are taken modulo 2^WIDTH with no exception. Example: 0 - 1 = 0xFFFFFFFF, borrow=1.
- Reset mid-operation:
  - Abort immediately and return to IDLE with all outputs at their reset values.
  - No done pulse is produced.
- a == b: diff=0, zero=1, borrow=0, overflow=0.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined:
  - When overflow=1 at completion, diff is clamped: 0x7FFFFFFF if a[MSB]=0, 0x80000000 if a[MSB]=1.
  - overflow still reports 1. borrow is computed from the unclamped result. zero is computed from the clamped diff.
- Undefined: diff always carries the wrapped result; there is no clamp logic.

Test Plan:
- a=0x0000000A, b=0x00000003, start for 1 cycle -> busy for 4 cycles, then done=1 for 1 cycle with diff=0x00000007, borrow=0, overflow=0, zero=0.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1, overflow=0, zero=0.
- a=0x80000000, b=0x00000001 -> without SUB_SATURATE_EN: diff=0x7FFFFFFF, overflow=1, borrow=0; with it: diff=0x80000000, overflow=1.
- a=b=0xAAAAAAAA; during RUN, toggle start and change a/b -> diff=0, zero=1; extra start pulses are ignored; exactly one done.
- Issue start again in the DONE cycle with a=5, b=5 -> second done exactly 5 cycles after the first, diff=0, zero=1.
- Assert rst_n=0 in the 2nd RUN cycle -> all outputs 0 immediately, no done pulse; after release, a new start completes normally.

Source files
------------

// File: rtl/sub_32bit_seq.sv
// rtl/sub_32bit_seq.sv - multi-cycle chunked subtractor (a - b) with borrow/overflow/zero flags
// Define SUB_SATURATE_EN to clamp the result to the signed range on overflow.
module sub_32bit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   sum;
    logic             ovf_now;
    logic [WIDTH-1:0] result;

    // One slice of a + ~b + carry; work_d already holds the slice just computed.
    always_comb begin
        a_sl   = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_sl   = b_q[int'(idx_q)*CHUNK +: CHUNK];
        sum    = {1'b0, a_sl} + {1'b0, ~b_sl} + {{CHUNK{1'b0}}, carry_q};
        work_d = work_q;
        if (state_q == S_RUN) begin
            work_d[int'(idx_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        end
        ovf_now = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SUB_SATURATE_EN
        if (ovf_now) begin
            result = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            result = work_d;
        end
`else
        result = work_d;
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    diff_d   = result;
                    borrow_d = ~sum[CHUNK];
                    ovf_d    = ovf_now;
                    zero_d   = (result == '0);
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule
